// File: rtl/pred_gate_if.sv
// Decision-gate bus: dispatch arm, predicate arrival, decision channel and
// status outputs. The master side drives requests; the slave side is the gate.
interface pred_gate_if #(
  parameter int NUM_SLOTS = 8,
  parameter int DATA_W    = 32,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
);
  logic                 flush;
  logic                 arm_valid;
  logic [SLOT_W-1:0]    arm_slot;
  logic                 arm_pred_en;
  logic                 arm_pred_true;
  logic                 pred_valid;
  logic [SLOT_W-1:0]    pred_slot;
  logic [DATA_W-1:0]    pred_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SLOT_W-1:0]    out_slot;
  logic                 out_fire;
  logic [NUM_SLOTS-1:0] busy_mask;
  logic                 arm_err;
  logic [15:0]          null_cnt;

  modport master (
    output flush, arm_valid, arm_slot, arm_pred_en, arm_pred_true,
           pred_valid, pred_slot, pred_data, out_ready,
    input  out_valid, out_slot, out_fire, busy_mask, arm_err, null_cnt
  );

  modport slave (
    input  flush, arm_valid, arm_slot, arm_pred_en, arm_pred_true,
           pred_valid, pred_slot, pred_data, out_ready,
    output out_valid, out_slot, out_fire, busy_mask, arm_err, null_cnt
  );
endinterface

// File: rtl/pred_gate.sv
// Predication gate: tracks NUM_SLOTS reservation-station slots, resolves each
// against its predicate operand and emits execute/nullify decisions, lowest
// slot first. Optional macro PRED_OR_EN: a waiting slot resolves only on a
// matching predicate (predicate-OR over several producers).

// One slot: IDLE -> (WAIT) -> RESOLVED -> IDLE.
module pred_gate_slot (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic arm_hit,
  input  logic arm_pred_en,
  input  logic arm_pred_true,
  input  logic pred_hit,
  input  logic pred_bit,
  input  logic rel,
  output logic resolved,
  output logic busy,
  output logic fire
);
  typedef enum logic [1:0] {IDLE, WAIT, RESOLVED} slot_state_e;

  slot_state_e state_q, state_d;
  logic        pol_q, pol_d;
  logic        fire_q, fire_d;

  // Next state: flush wins; arm only lands on IDLE, predicate only on WAIT.
  always_comb begin
    state_d = state_q;
    pol_d   = pol_q;
    fire_d  = fire_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (arm_hit) begin
          if (arm_pred_en) begin
            state_d = WAIT;
            pol_d   = arm_pred_true;
          end else begin
            state_d = RESOLVED;
            fire_d  = 1'b1;
          end
        end
        WAIT: if (pred_hit) begin
`ifdef PRED_OR_EN
          if (pred_bit == pol_q) begin
            state_d = RESOLVED;
            fire_d  = 1'b1;
          end
`else
          state_d = RESOLVED;
          fire_d  = (pred_bit == pol_q);
`endif
        end
        RESOLVED: if (rel) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pol_q   <= 1'b0;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pol_q   <= pol_d;
      fire_q  <= fire_d;
    end
  end

  assign resolved = (state_q == RESOLVED);
  assign busy     = (state_q != IDLE);
  assign fire     = fire_q;
endmodule

module pred_gate #(
  parameter int NUM_SLOTS = 8,
  parameter int DATA_W    = 32,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input logic        clk,
  input logic        rst,
  pred_gate_if.slave bus
);
  logic [NUM_SLOTS-1:0] resolved, busy, fire;
  logic                 any_res;
  logic [SLOT_W-1:0]    sel;
  logic                 hs;
  logic                 arm_err_q;
  logic [15:0]          null_q;

  // Per-slot trackers; decode of arm/predicate/release is one-hot per slot.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    pred_gate_slot u_slot (
      .clk          (clk),
      .rst          (rst),
      .flush        (bus.flush),
      .arm_hit      (bus.arm_valid && (bus.arm_slot == SLOT_W'(g))),
      .arm_pred_en  (bus.arm_pred_en),
      .arm_pred_true(bus.arm_pred_true),
      .pred_hit     (bus.pred_valid && (bus.pred_slot == SLOT_W'(g))),
      .pred_bit     (bus.pred_data[0]),
      .rel          (hs && (sel == SLOT_W'(g))),
      .resolved     (resolved[g]),
      .busy         (busy[g]),
      .fire         (fire[g])
    );
  end

  // Only the predicate LSB carries meaning.
  if (DATA_W > 1) begin : g_unused
    logic unused_pred_hi;
    assign unused_pred_hi = ^bus.pred_data[DATA_W-1:1];
  end

  // Lowest-indexed RESOLVED slot wins the decision channel.
  always_comb begin
    any_res = |resolved;
    sel     = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (resolved[i]) sel = SLOT_W'(i);
  end

  assign bus.out_valid = any_res && !bus.flush;
  assign bus.out_slot  = sel;
  assign bus.out_fire  = bus.out_valid && fire[sel];
  assign hs            = bus.out_valid && bus.out_ready;

  // Illegal-arm pulse and saturating nullify counter; flush suppresses both
  // the arm and the handshake (out_valid is already low under flush).
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_err_q <= 1'b0;
      null_q    <= '0;
    end else begin
      arm_err_q <= bus.arm_valid && !bus.flush && busy[bus.arm_slot];
      if (hs && !fire[sel] && (null_q != 16'hFFFF))
        null_q <= null_q + 16'd1;
    end
  end

  assign bus.busy_mask = busy;
  assign bus.arm_err   = arm_err_q;
  assign bus.null_cnt  = null_q;
endmodule

// File: tb/tb_pred_gate.sv
// Bench for pred_gate: table of single-slot decisions plus hand sequences for
// ordering, hold, illegal arm, flush, reset and counter saturation.
module tb_pred_gate;
  localparam int NS = 8;
  localparam int DW = 32;
  localparam int SW = 3;
`ifdef PRED_OR_EN
  localparam bit OR_EN = 1'b1;
`else
  localparam bit OR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pred_gate_if #(.NUM_SLOTS(NS), .DATA_W(DW), .SLOT_W(SW)) bus ();
  pred_gate #(.NUM_SLOTS(NS), .DATA_W(DW), .SLOT_W(SW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { logic [SW-1:0] slot; logic fire; } dec_t;
  typedef struct {
    int slot; bit en; bit t; bit use_pred; logic [DW-1:0] data; bit exp_fire;
  } vec_t;

  dec_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   exp_null = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    bus.flush = 1'b0; bus.arm_valid = 1'b0; bus.pred_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_arm(input int s, input bit en, input bit t);
    bus.arm_valid = 1'b1; bus.arm_slot = SW'(s);
    bus.arm_pred_en = en; bus.arm_pred_true = t;
    tick(); clr();
  endtask

  task automatic do_pred(input int s, input logic [DW-1:0] d);
    bus.pred_valid = 1'b1; bus.pred_slot = SW'(s); bus.pred_data = d;
    tick(); clr();
  endtask

  // Pop the expected decision, compare, then handshake it.
  task automatic take(input string nm);
    dec_t e;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty, got valid=%0b", nm, bus.out_valid);
      return;
    end
    e = sb.pop_front();
    chk({nm, ".valid"}, bus.out_valid, 1);
    chk({nm, ".slot"}, bus.out_slot, e.slot);
    chk({nm, ".fire"}, bus.out_fire, e.fire);
    bus.out_ready = 1'b1;
    tick(); clr();
    if (!e.fire && exp_null < 65535) exp_null++;
    chk({nm, ".null_cnt"}, bus.null_cnt, exp_null);
  endtask

  // Pipelined nullify stream: arm slot k _t, predicate 0 to slot k-1, always ready.
  task automatic null_burst(input int n);
    for (int k = 0; k <= n; k++) begin
      bus.arm_valid = (k < n); bus.arm_slot = SW'(k % NS);
      bus.arm_pred_en = 1'b1; bus.arm_pred_true = 1'b1;
      bus.pred_valid = (k >= 1); bus.pred_slot = SW'((k + NS - 1) % NS);
      bus.pred_data = '0;
      bus.out_ready = 1'b1;
      tick();
    end
    clr(); bus.out_ready = 1'b1;
    tick(); tick(); tick();
    clr();
    exp_null = (exp_null + n > 65535) ? 65535 : exp_null + n;
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{3, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1};
    tbl[1] = '{5, 1'b1, 1'b1, 1'b1, 32'h0,         1'b0};
    tbl[2] = '{4, 1'b1, 1'b0, 1'b1, 32'h0,         1'b1};
    tbl[3] = '{0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1};
    tbl[4] = '{7, 1'b1, 1'b0, 1'b1, 32'h2,         1'b1};
    tbl[5] = '{6, 1'b1, 1'b0, 1'b1, 32'h3,         1'b0};

    clr(); bus.arm_slot = '0; bus.arm_pred_en = 1'b0; bus.arm_pred_true = 1'b0;
    bus.pred_slot = '0; bus.pred_data = '0;
    rst = 1'b1;
    tick(); tick();
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.out_slot", bus.out_slot, 0);
    chk("rst.out_fire", bus.out_fire, 0);
    chk("rst.busy_mask", bus.busy_mask, 0);
    chk("rst.arm_err", bus.arm_err, 0);
    chk("rst.null_cnt", bus.null_cnt, 0);
    rst = 1'b0;
    tick();

    // Single-slot decisions: unpredicated latency, _t/_f, LSB-only predicate.
    for (int i = 0; i < 6; i++) begin
      do_arm(tbl[i].slot, tbl[i].en, tbl[i].t);
      chk($sformatf("vec%0d.arm_err", i), bus.arm_err, 0);
      if (tbl[i].use_pred) begin
        chk($sformatf("vec%0d.wait", i), bus.out_valid, 0);
        do_pred(tbl[i].slot, tbl[i].data);
        if (OR_EN && (tbl[i].data[0] != tbl[i].t)) begin
          chk($sformatf("vec%0d.or_hold", i), bus.out_valid, 0);
          chk($sformatf("vec%0d.or_busy", i), bus.busy_mask[tbl[i].slot], 1);
          do_pred(tbl[i].slot, DW'(tbl[i].t));
        end
      end
      sb.push_back('{SW'(tbl[i].slot), OR_EN ? 1'b1 : tbl[i].exp_fire});
      take($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.busy_clr", i), bus.busy_mask, 0);
    end

    // Slot 6 unpredicated and slot 2 predicate resolve together; 2 wins and holds.
    do_arm(2, 1'b1, 1'b0);
    bus.arm_valid = 1'b1; bus.arm_slot = 3'd6; bus.arm_pred_en = 1'b0;
    bus.pred_valid = 1'b1; bus.pred_slot = 3'd2; bus.pred_data = '0;
    tick(); clr();
    chk("order.first", bus.out_slot, 2);
    tick();
    chk("order.hold_valid", bus.out_valid, 1);
    chk("order.hold_slot", bus.out_slot, 2);
    sb.push_back('{3'd2, 1'b1});
    sb.push_back('{3'd6, 1'b1});
    take("order.s2");
    take("order.s6");
    chk("order.busy", bus.busy_mask, 0);

    // Second arm to a waiting slot is rejected and leaves it alone.
    do_arm(1, 1'b1, 1'b0);
    chk("dup.first_err", bus.arm_err, 0);
    do_arm(1, 1'b0, 1'b0);
    chk("dup.err", bus.arm_err, 1);
    chk("dup.still_wait", bus.out_valid, 0);
    chk("dup.busy", bus.busy_mask, 8'h02);
    tick();
    chk("dup.err_pulse", bus.arm_err, 0);
    do_pred(1, 32'h0);
    sb.push_back('{3'd1, 1'b1});
    take("dup.resolve");

    // Arm and predicate to the same idle slot: only the arm lands.
    bus.arm_valid = 1'b1; bus.arm_slot = 3'd4; bus.arm_pred_en = 1'b1;
    bus.arm_pred_true = 1'b1;
    bus.pred_valid = 1'b1; bus.pred_slot = 3'd4; bus.pred_data = 32'h1;
    tick(); clr();
    chk("same.wait", bus.out_valid, 0);
    chk("same.busy", bus.busy_mask, 8'h10);
    do_pred(4, 32'h1);
    sb.push_back('{3'd4, 1'b1});
    take("same.resolve");

    // Arm to a slot being released this cycle is still illegal.
    do_arm(3, 1'b0, 1'b0);
    chk("rel.slot", bus.out_slot, 3);
    bus.out_ready = 1'b1;
    bus.arm_valid = 1'b1; bus.arm_slot = 3'd3; bus.arm_pred_en = 1'b0;
    tick(); clr();
    chk("rel.err", bus.arm_err, 1);
    chk("rel.idle", bus.busy_mask, 0);
    chk("rel.no_valid", bus.out_valid, 0);

    // Flush with ready high: nothing delivered, nothing counted.
    do_arm(0, 1'b1, 1'b1);
    do_pred(0, 32'h0);
    do_arm(4, 1'b0, 1'b0);
    do_arm(7, 1'b0, 1'b0);
    chk("flush.pre_busy", bus.busy_mask, 8'h91);
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    #1;
    chk("flush.valid_low", bus.out_valid, 0);
    tick(); clr();
    chk("flush.busy", bus.busy_mask, 0);
    chk("flush.null_cnt", bus.null_cnt, exp_null);
    chk("flush.out_valid", bus.out_valid, 0);

    // Reset mid-operation drops pending decisions.
    do_arm(2, 1'b0, 1'b0);
    do_arm(5, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_null = 0;
    chk("rst2.out_valid", bus.out_valid, 0);
    chk("rst2.busy", bus.busy_mask, 0);
    chk("rst2.null_cnt", bus.null_cnt, 0);
    tick();

`ifndef PRED_OR_EN
    // Counter runs up to and sticks at 0xFFFF.
    null_burst(65534);
    chk("sat.fffe", bus.null_cnt, exp_null);
    null_burst(1);
    chk("sat.ffff", bus.null_cnt, 16'hFFFF);
    null_burst(1);
    chk("sat.hold", bus.null_cnt, 16'hFFFF);
    chk("sat.busy", bus.busy_mask, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
